// File: rtl/pixel_pkg.sv
// Shared pixel types and constants for the VGA pixel path.
package pixel_pkg;

    localparam int COLOR_BITS = 4;
    localparam int PIXEL_BITS = 3 * COLOR_BITS;

    // {R[3:0], G[3:0], B[3:0]}
    typedef logic [PIXEL_BITS-1:0] pixel_t;

    localparam pixel_t DEFAULT_UNDERFLOW_COLOR = 12'h000;

endpackage

// File: rtl/pixel_fifo_mem.sv
// DEPTH x pixel storage: synchronous write, asynchronous read, contents never reset.
module pixel_fifo_mem
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pixel_fifo.sv
// Elastic show-ahead pixel buffer feeding the VGA timing generator; flushed on vsync.
// Optional underflow statistics counter is enabled with PIXEL_FIFO_STATS_EN.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int     DEPTH           = 16,
    parameter pixel_t UNDERFLOW_COLOR = DEFAULT_UNDERFLOW_COLOR
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  pixel_t                   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     visible_area,
    input  logic                     vsync,
    output pixel_t                   data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow,
    input  logic                     underflow_clear
`ifdef PIXEL_FIFO_STATS_EN
    ,
    output logic [15:0]              underflow_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    pixel_t        rd_data;
    logic          full;
    logic          empty;
    logic          flush;
    logic          push;
    logic          pop;
    logic          underflow_event;

    // Handshake: a word transfers on a clock edge where in_valid && in_ready are both
    // high; in_ready does not depend on in_valid, and the producer holds in_data
    // stable while in_valid is high and in_ready is low.
    assign full            = (level == LW'(DEPTH));
    assign empty           = (level == '0);
    assign flush           = !vsync;
    assign in_ready        = !full && vsync;
    assign push            = in_valid && in_ready;
    assign pop             = visible_area && !empty;
    assign underflow_event = visible_area && empty;

    assign data = empty ? UNDERFLOW_COLOR : rd_data;

    pixel_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // A fresh underflow event outranks a clear in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow <= 1'b0;
        end else if (underflow_event) begin
            underflow <= 1'b1;
        end else if (underflow_clear) begin
            underflow <= 1'b0;
        end
    end

`ifdef PIXEL_FIFO_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow_count <= '0;
        end else if (underflow_clear) begin
            underflow_count <= underflow_event ? 16'd1 : 16'd0;
        end else if (underflow_event && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// Directed self-checking bench for pixel_fifo (default DEPTH = 16).
module tb_pixel_fifo;
    import pixel_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset_n;
    pixel_t        in_data;
    logic          in_valid;
    logic          in_ready;
    logic          visible_area;
    logic          vsync;
    pixel_t        data;
    logic [LW-1:0] level;
    logic          underflow;
    logic          underflow_clear;
`ifdef PIXEL_FIFO_STATS_EN
    logic [15:0]   underflow_count;
`endif

    int checks;
    int errors;
    logic [11:0] exp_q[$];

    pixel_fifo #(
        .DEPTH           (DEPTH),
        .UNDERFLOW_COLOR (12'h000)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .visible_area    (visible_area),
        .vsync           (vsync),
        .data            (data),
        .level           (level),
        .underflow       (underflow),
        .underflow_clear (underflow_clear)
`ifdef PIXEL_FIFO_STATS_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        in_valid        = 1'b0;
        in_data         = '0;
        visible_area    = 1'b0;
        vsync           = 1'b1;
        underflow_clear = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic push_word(input logic [11:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (data !== 12'h000) begin errors++; $display("FAIL reset_data got %h exp 000", data); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic_push();
        do_reset();
        push_word(12'hF00);
        push_word(12'h0F0);
        push_word(12'h00F);
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL basic_level got %0d exp 3", level); end
        checks++; if (data !== 12'hF00) begin errors++; $display("FAIL basic_data got %h exp F00", data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b exp 1", in_ready); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL basic_underflow got %b exp 0", underflow); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 16; i++) push_word(12'(i));
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        checks++; if (data !== 12'h001) begin errors++; $display("FAIL full_head got %h exp 001", data); end
        push_word(12'h011);
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_17th_level got %0d exp 16", level); end
        checks++; if (data !== 12'h001) begin errors++; $display("FAIL full_17th_head got %h exp 001", data); end
        visible_area = 1'b1;
        step();
        visible_area = 1'b0;
        checks++; if (data !== 12'h002) begin errors++; $display("FAIL full_pop_data got %h exp 002", data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready got %b exp 1", in_ready); end
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_pop_level got %0d exp 15", level); end
    endtask

    task automatic test_underflow();
        do_reset();
        visible_area = 1'b1;
        repeat (3) step();
        visible_area = 1'b0;
        checks++; if (data !== 12'h000) begin errors++; $display("FAIL uf_data got %h exp 000", data); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", underflow); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL uf_level got %0d exp 0", level); end
`ifdef PIXEL_FIFO_STATS_EN
        checks++; if (underflow_count !== 16'd3) begin errors++; $display("FAIL uf_count got %0d exp 3", underflow_count); end
`endif
        underflow_clear = 1'b1;
        step();
        underflow_clear = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", underflow); end
`ifdef PIXEL_FIFO_STATS_EN
        checks++; if (underflow_count !== 16'd0) begin errors++; $display("FAIL uf_count_clear got %0d exp 0", underflow_count); end
`endif
        // clear and event together: event wins
        underflow_clear = 1'b1;
        visible_area    = 1'b1;
        step();
        underflow_clear = 1'b0;
        visible_area    = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_clear_vs_event got %b exp 1", underflow); end
`ifdef PIXEL_FIFO_STATS_EN
        checks++; if (underflow_count !== 16'd1) begin errors++; $display("FAIL uf_count_clear_vs_event got %0d exp 1", underflow_count); end
`endif
        underflow_clear = 1'b1;
        step();
        underflow_clear = 1'b0;
        // push and pop request together while empty: no pop, word shows next cycle, underflow sets
        in_data      = 12'h5A5;
        in_valid     = 1'b1;
        visible_area = 1'b1;
        step();
        in_valid     = 1'b0;
        visible_area = 1'b0;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL empty_pushpop_level got %0d exp 1", level); end
        checks++; if (data !== 12'h5A5) begin errors++; $display("FAIL empty_pushpop_data got %h exp 5A5", data); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_pushpop_uf got %b exp 1", underflow); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) push_word(12'h300 + 12'(i));
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got %0d exp 5", level); end
        vsync    = 1'b0;
        in_data  = 12'hABC;
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_0 got %b exp 0", in_ready); end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level cyc %0d got %0d exp 0", c, level); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready cyc %0d got %b exp 0", c, in_ready); end
        end
        checks++; if (data !== 12'h000) begin errors++; $display("FAIL flush_data got %h exp 000", data); end
        vsync = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL flush_after_level got %0d exp 1", level); end
        checks++; if (data !== 12'hABC) begin errors++; $display("FAIL flush_after_addr0 got %h exp ABC", data); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL flush_underflow got %b exp 0", underflow); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_word;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_word(12'h100 + 12'(i));
            exp_q.push_back(12'h100 + 12'(i));
        end
        checks++; if (level !== 5'd8) begin errors++; $display("FAIL b2b_pre_level got %0d exp 8", level); end
        for (int i = 0; i < 100; i++) begin
            in_data      = 12'h108 + 12'(i);
            in_valid     = 1'b1;
            visible_area = 1'b1;
            #1;
            exp_word = exp_q.pop_front();
            exp_q.push_back(in_data);
            checks++; if (data !== exp_word) begin errors++; $display("FAIL b2b_data cyc %0d got %h exp %h", i, data, exp_word); end
            @(posedge clock);
            #1;
            checks++; if (level !== 5'd8) begin errors++; $display("FAIL b2b_level cyc %0d got %0d exp 8", i, level); end
        end
        in_valid     = 1'b0;
        visible_area = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) push_word(12'h700 + 12'(i));
        checks++; if (level !== 5'd7) begin errors++; $display("FAIL rst_mid_pre_level got %0d exp 7", level); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", level); end
        checks++; if (data !== 12'h000) begin errors++; $display("FAIL rst_mid_data got %h exp 000", data); end
        in_data  = 12'hEEE;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_held_push got %0d exp 0", level); end
        reset_n = 1'b1;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_push();
        test_full();
        test_underflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_fifo.md
# pixel_fifo

- Elastic pixel buffer directly upstream of the VGA timing generator.
- Accepts 12-bit RGB444 pixels from the bus/rasterizer side through a valid/ready handshake.
- Presents the head pixel on the generator's `data` input and pops one pixel per cycle while the generator reports `visible_area`.
- Flushes on every vsync pulse so frames realign, and flags underflow when the display outruns the producer.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4
- UNDERFLOW_COLOR, 12'h000, pixel driven while empty

Ports:
- clock  in  1  pixel clock, shared with the VGA generator
- reset_n  in  1  asynchronous active-low reset
- in_data  in  12  pixel from producer, {R[3:0],G[3:0],B[3:0]}
- in_valid  in  1  producer has a pixel on in_data
- in_ready  out  1  FIFO accepts in_data this cycle
- visible_area  in  1  from VGA generator; pop request
- vsync  in  1  from VGA generator, active-low sync pulse
- data  out  12  pixel to VGA generator
- level  out  $clog2(DEPTH)+1  current occupancy
- underflow  out  1  sticky: pop attempted while empty
- underflow_clear  in  1  clears underflow

## Operation
- Push: in_valid && in_ready writes in_data at the write pointer; write pointer increments modulo DEPTH.
- in_ready = (level != DEPTH) && vsync (combinational).
- Pop: visible_area && (level != 0) advances the read pointer modulo DEPTH.
- data is combinational: UNDERFLOW_COLOR when level == 0, otherwise mem[read pointer] (show-ahead).
- Underflow: visible_area && level == 0 sets underflow. No pointer movement.
- Underflow clear:
  - underflow_clear clears underflow next cycle.
  - A simultaneous underflow event wins, so the flag stays 1.
- Flush: while vsync == 0, both pointers and level go to 0 each cycle and pushes are refused. Stored data is discarded. underflow is not affected.
- Simultaneous push and pop:
  - level unchanged.
  - If level == 0, no pop happens; the pushed word becomes visible on data the next cycle and underflow sets.
- level arithmetic: +1 on push only, −1 on pop only. Never exceeds DEPTH and never goes below 0.

## Timing
- Reset (reset_n low, asynchronous): pointers 0, level 0, underflow 0, data = UNDERFLOW_COLOR. Pushes are ignored while reset is held.
- Push-to-data latency: a word pushed into an empty FIFO at edge N appears on data after edge N.
- The VGA generator samples data at the same edge where visible_area is high. The pop and the downstream capture happen on that same edge.
- Full boundary:
  - At level == DEPTH, in_ready is 0.
  - A pop at level == DEPTH raises in_ready the cycle after.
  - There is no same-cycle push-through when full.
- Reset mid-operation: all state is dropped immediately. No partial words survive.
- Flush and push both requested in the same cycle: flush wins and the push is not accepted.

## Configuration
Macro: PIXEL_FIFO_STATS_EN.
- Defined:
  - Adds output underflow_count [15:0].
  - Increments on each underflow cycle and saturates at 16'hFFFF.
  - Reset to 0 by reset_n or underflow_clear.
  - If both a clear and an event occur in the same cycle, the count becomes 1.
- Undefined: port and counter absent. All other behaviour is identical.

## Structure
- Shared package pixel_pkg:
  - pixel_t (12-bit).
  - Channel width constant COLOR_BITS = 4.
  - Default UNDERFLOW_COLOR.
- Sub-module pixel_fifo_mem:
  - DEPTH×12 storage, synchronous write, asynchronous read, no reset on contents.
  - pixel_fifo owns pointers, level, flags and handshake.

## Test plan
- Reset, then push 12'hF00, 12'h0F0, 12'h00F with visible_area = 0 -> level = 3, data = 12'hF00, in_ready = 1, underflow = 0.
- Fill 16 words 12'h001..12'h010 with no pop -> level = 16 and in_ready = 0; a 17th in_valid is not accepted. One visible_area pulse -> data = 12'h002 and in_ready = 1 next cycle.
- Empty FIFO, visible_area = 1 for 3 cycles -> data = UNDERFLOW_COLOR, underflow = 1, level stays 0. With PIXEL_FIFO_STATS_EN, underflow_count = 3. underflow_clear -> 0.
- level = 5, vsync low for 2 cycles with in_valid = 1 -> level = 0, in_ready = 0 throughout, no words accepted. vsync high -> next push is accepted and lands at address 0.
- Continuous push and pop at level = 8 for 100 cycles -> level stays 8 and data sequence equals input sequence delayed by 8 pops. Pointer wrap is exercised.
- Assert reset_n low mid-stream at level = 7 -> level = 0 and data = UNDERFLOW_COLOR immediately, without waiting for a clock edge.
